top_writeback: RTL
==================

# top_writeback

Final core pipeline stage, directly downstream of the MemoryAccess stage. It consumes the stage latch from MemoryAccess, selects the destination-register data from one of four sources (ALU, data memory, CSR, link address), and drives the register-file write port. It owns the architectural PC register and the retire bookkeeping, and raises a sticky error on a misaligned control-transfer target.

## Interface
- XLEN, 32 (64 when RV64I is defined): data/address width.
- OPLEN, core-wide decoded-opcode width, from the shared core header.
- RESET_VECTOR, 0: PC value after reset.
- Decoded-opcode fields used, defined in the shared core header:
  - RF_WE_BIT: rd write request.
  - WB_SEL_BIT_H:WB_SEL_BIT_L: 2-bit source select. 00 = ALU, 01 = MEM, 10 = CSR, 11 = LINK.
- Ports:
  - clk  in  1  global clock.
  - rst_n  in  1  global reset; asynchronous, active-low.
  - phase_writeback  in  1  WriteBack phase strobe from StateMachine.
  - decoded_op_mw  in  OPLEN  decoded opcode.
  - jump_state_mw  in  1  next PC is a jump target.
  - rdsel_mw  in  5  destination register.
  - next_pc_mw  in  XLEN  next PC address.
  - alu_out_mw  in  XLEN  ALU result.
  - mem_out_mw  in  XLEN  load data, already extended.
  - csr_out_mw  in  XLEN  CSR read data.
  - rf_we  out  1  register-file write enable.
  - rf_wsel  out  5  register-file write address.
  - rf_wdata  out  XLEN  register-file write data.
  - pc  out  XLEN  architectural PC, registered.
  - jump_taken  out  1  last retired instruction redirected the PC, registered.
  - fwd_valid  out  1  forwarding entry valid, registered.
  - fwd_rd  out  5  last written rd, registered.
  - fwd_data  out  XLEN  last written data, registered.
  - misalign_err  out  1  sticky misaligned-target flag.
  - instret  out  64  retired-instruction count (only with RETIRE_COUNTER_EN).
  - stall_writeback  out  1  stall request to StateMachine.

## Operation
- Data select (combinational), per WB_SEL:
  - 00: alu_out_mw.
  - 01: mem_out_mw.
  - 10: csr_out_mw.
  - 11: LINK = pc + 4, computed modulo 2^XLEN.
- Misaligned target: mis = next_pc_mw[1:0] != 2'b00.
- Write port (combinational):
  - rf_we = phase_writeback & RF_WE & (rdsel_mw != 0) & ~mis.
  - rf_wsel = rdsel_mw.
  - rf_wdata = selected data.
  - Writes to x0 are never issued.
- Retire happens on the rising clk edge while phase_writeback = 1.
  - mis = 0:
    - pc <= next_pc_mw.
    - jump_taken <= jump_state_mw.
    - fwd_valid <= rf_we; fwd_rd and fwd_data are updated only when rf_we = 1.
  - mis = 1:
    - pc holds its value; no register write.
    - misalign_err <= 1.
    - jump_taken <= 0; fwd_valid <= 0.
- misalign_err clears only on reset. The core continues to run; StateMachine decides whether to halt.
- When phase_writeback = 0, all registers hold their values.
- stall_writeback is tied to 0: writeback completes in one clk.

## Timing
- Reset values (asynchronous, on rst_n low):
  - pc = RESET_VECTOR.
  - jump_taken = 0, fwd_valid = 0, fwd_rd = 0, fwd_data = 0.
  - misalign_err = 0, instret = 0.
  - rf_we = 0 while phase_writeback = 0.
- rf_we, rf_wsel and rf_wdata are combinational and valid during the phase_writeback cycle. The register file samples them on the same edge.
- pc, jump_taken, fwd_* and instret update 1 clk after the phase cycle, on the edge that ends it.
- Reset asserted mid-phase: registers clear immediately. The partial retire is lost and nothing is counted.
- Back-to-back phases, one per cycle, are legal. Each phase retires exactly once.
- PC wrap-around: LINK of pc = 2^XLEN-4 is 0.

## Configuration
- RETIRE_COUNTER_EN defined:
  - 64-bit instret counter, incremented by 1 on each retire with mis = 0.
  - Misaligned retires are not counted.
  - The counter wraps 2^64-1 -> 0.
- RETIRE_COUNTER_EN undefined:
  - instret port absent, no counter logic.
  - All other behaviour is identical.

## Test plan
- Reset, then release: pc = RESET_VECTOR, all flags 0, instret = 0. One ALU op with rd = 5, alu_out_mw = 0x1234, next_pc_mw = 0x4 -> rf_we = 1, rf_wsel = 5, rf_wdata = 0x1234. Next cycle: pc = 0x4, fwd_rd = 5, fwd_data = 0x1234, instret = 1.
- Each WB_SEL source with distinct values (ALU 0xA, MEM 0xB, CSR 0xC, LINK with pc = 0x100) -> rf_wdata = 0xA, 0xB, 0xC, 0x104 respectively.
- rd = 0 with RF_WE = 1 -> rf_we = 0. Next cycle: fwd_valid = 0, pc advances, instret increments.
- JAL with jump_state_mw = 1, next_pc_mw = 0x80, pc = 0x10 -> rf_wdata = 0x14. Next cycle: jump_taken = 1, pc = 0x80. Then jump to 0x82 -> rf_we = 0, pc stays 0x80, misalign_err = 1 and stays set, instret unchanged.
- phase_writeback held low for 3 cycles with changing inputs -> no rf_we and all registers hold. Assert rst_n low mid-phase -> all outputs return to reset values in the same cycle.
- Counter wrap with RETIRE_COUNTER_EN: force instret to 2^64-1, retire once -> instret = 0.

Source files
------------

// File: rtl/top_writeback_if.sv
// rtl/top_writeback_if.sv - MemoryAccess-to-WriteBack stage latch bundle
interface top_writeback_if #(
    parameter int XLEN  = 32,
    parameter int OPLEN = 8
);
    logic             phase_writeback;
    logic [OPLEN-1:0] decoded_op_mw;
    logic             jump_state_mw;
    logic [4:0]       rdsel_mw;
    logic [XLEN-1:0]  next_pc_mw;
    logic [XLEN-1:0]  alu_out_mw;
    logic [XLEN-1:0]  mem_out_mw;
    logic [XLEN-1:0]  csr_out_mw;

    modport master (
        output phase_writeback, decoded_op_mw, jump_state_mw, rdsel_mw,
               next_pc_mw, alu_out_mw, mem_out_mw, csr_out_mw
    );

    modport slave (
        input  phase_writeback, decoded_op_mw, jump_state_mw, rdsel_mw,
               next_pc_mw, alu_out_mw, mem_out_mw, csr_out_mw
    );
endinterface

// File: rtl/top_writeback.sv
// rtl/top_writeback.sv - WriteBack stage: rd data select, PC/retire state; RETIRE_COUNTER_EN adds instret
module top_writeback #(
`ifdef RV64I
    parameter int XLEN = 64,
`else
    parameter int XLEN = 32,
`endif
    parameter int OPLEN = 8,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    top_writeback_if.slave    mw,
    output logic              rf_we,
    output logic [4:0]        rf_wsel,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [XLEN-1:0]   pc,
    output logic              jump_taken,
    output logic              fwd_valid,
    output logic [4:0]        fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
    output logic              misalign_err,
    output logic              stall_writeback
`ifdef RETIRE_COUNTER_EN
    ,
    output logic [63:0]       instret
`endif
);
    localparam int RF_WE_BIT    = 0;
    localparam int WB_SEL_BIT_L = 1;
    localparam int WB_SEL_BIT_H = 2;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            jump_taken_q, jump_taken_d;
    logic            fwd_valid_q, fwd_valid_d;
    logic [4:0]      fwd_rd_q, fwd_rd_d;
    logic [XLEN-1:0] fwd_data_q, fwd_data_d;
    logic            misalign_err_q, misalign_err_d;

    logic [1:0]      wb_sel;
    logic            mis;
    logic [XLEN-1:0] link_addr;
    logic            unused_op_bits;

    assign wb_sel         = mw.decoded_op_mw[WB_SEL_BIT_H:WB_SEL_BIT_L];
    assign mis            = mw.next_pc_mw[1:0] != 2'b00;
    assign link_addr      = pc_q + XLEN'(4);
    assign unused_op_bits = ^mw.decoded_op_mw[OPLEN-1:WB_SEL_BIT_H+1];

    always_comb begin
        rf_wdata = mw.alu_out_mw;
        case (wb_sel)
            2'b00:   rf_wdata = mw.alu_out_mw;
            2'b01:   rf_wdata = mw.mem_out_mw;
            2'b10:   rf_wdata = mw.csr_out_mw;
            default: rf_wdata = link_addr;
        endcase
    end

    // x0 and misaligned control transfers never reach the register file
    assign rf_we   = mw.phase_writeback & mw.decoded_op_mw[RF_WE_BIT]
                   & (mw.rdsel_mw != 5'd0) & ~mis;
    assign rf_wsel = mw.rdsel_mw;

    always_comb begin
        pc_d           = pc_q;
        jump_taken_d   = jump_taken_q;
        fwd_valid_d    = fwd_valid_q;
        fwd_rd_d       = fwd_rd_q;
        fwd_data_d     = fwd_data_q;
        misalign_err_d = misalign_err_q;
        if (mw.phase_writeback) begin
            if (mis) begin
                misalign_err_d = 1'b1;
                jump_taken_d   = 1'b0;
                fwd_valid_d    = 1'b0;
            end else begin
                pc_d         = mw.next_pc_mw;
                jump_taken_d = mw.jump_state_mw;
                fwd_valid_d  = rf_we;
                if (rf_we) begin
                    fwd_rd_d   = mw.rdsel_mw;
                    fwd_data_d = rf_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= RESET_VECTOR;
            jump_taken_q   <= 1'b0;
            fwd_valid_q    <= 1'b0;
            fwd_rd_q       <= 5'd0;
            fwd_data_q     <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            jump_taken_q   <= jump_taken_d;
            fwd_valid_q    <= fwd_valid_d;
            fwd_rd_q       <= fwd_rd_d;
            fwd_data_q     <= fwd_data_d;
            misalign_err_q <= misalign_err_d;
        end
    end

`ifdef RETIRE_COUNTER_EN
    logic [63:0] instret_q, instret_d;

    assign instret_d = (mw.phase_writeback && !mis) ? instret_q + 64'd1 : instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) instret_q <= 64'd0;
        else        instret_q <= instret_d;
    end

    assign instret = instret_q;
`endif

    assign pc              = pc_q;
    assign jump_taken      = jump_taken_q;
    assign fwd_valid       = fwd_valid_q;
    assign fwd_rd          = fwd_rd_q;
    assign fwd_data        = fwd_data_q;
    assign misalign_err    = misalign_err_q;
    assign stall_writeback = 1'b0;
endmodule
